// File: rtl/cnn_burst_reader_if.sv
// Bus bundle for cnn_burst_reader: command, Avalon-MM read master,
// output stream and status. master = the reader, slave = its environment.
interface cnn_burst_reader_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 24,
   parameter int BC_W   = 5
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;

   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic [BC_W-1:0]   avm_burstcount;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;

   logic [DATA_W-1:0] st_data;
   logic              st_valid;
   logic              st_ready;
   logic              st_last;

   logic              busy;
   logic              done;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  st_ready,
      output cmd_ready,
      output avm_address, avm_read, avm_burstcount,
      output st_data, st_valid, st_last,
      output busy, done
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      output st_ready,
      input  cmd_ready,
      input  avm_address, avm_read, avm_burstcount,
      input  st_data, st_valid, st_last,
      input  busy, done
   );
endinterface

// File: rtl/cnn_burst_reader.sv
// cnn_burst_reader: splits one (addr, len) command into Avalon-MM bursts
// and streams returned words out through a show-ahead FIFO.
// Ports: clk_clk, reset_reset (sync, active high), bus (master modport):
//   cmd_*   command handshake, cmd_ready high only when idle
//   avm_*   burst read master, requests gated by FIFO credit
//   st_*    ready/valid stream, st_last on final word of a command
//   busy    high outside idle, done one-cycle completion pulse
module cnn_burst_reader #(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 24,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   cnn_burst_reader_if.master bus
);

   localparam int BC_W  = $clog2(MAX_BURST) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BSH   = $clog2(DATA_W / 8);

   localparam logic [BC_W-1:0]  MAXB  = BC_W'(MAX_BURST);
   localparam logic [LEN_W-1:0] MAXBL = LEN_W'(MAX_BURST);
   localparam logic [CNT_W:0]   DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   state_t            state;
   logic              cmd_ready_q;
   logic              busy_q;
   logic              done_q;
   logic              avm_read_q;
   logic [ADDR_W-1:0] avm_addr_q;
   logic [BC_W-1:0]   avm_bc_q;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  to_deliver;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  fifo_count;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic              fifo_wr;
   logic              fifo_rd;
   logic              st_valid;
   logic              accept;
   logic              cmd_acc;
   logic [CNT_W-1:0]  fifo_count_nxt;
   logic [CNT_W-1:0]  out_nxt;
   logic [LEN_W-1:0]  rem_acc;
   logic [LEN_W-1:0]  rem_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [BC_W-1:0]   bc_nxt;
   logic [BC_W-1:0]   bc_cmd;
   logic [LEN_W-1:0]  td_nxt;
   logic              credit_ok;

   function automatic logic [BC_W-1:0] burst_of(input logic [LEN_W-1:0] n);
      if (n >= MAXBL) begin
         return MAXB;
      end
      return BC_W'(n);
   endfunction

   // Credit is judged on next-cycle counts so a burst can follow an
   // accept back to back without ever promising more than the FIFO holds.
   always_comb begin
      fifo_wr        = bus.avm_readdatavalid;
      st_valid       = (fifo_count != '0);
      fifo_rd        = st_valid && bus.st_ready;
      accept         = avm_read_q && !bus.avm_waitrequest;
      cmd_acc        = bus.cmd_valid && cmd_ready_q;
      fifo_count_nxt = fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
      out_nxt        = outstanding - CNT_W'(fifo_wr);
      if (accept) begin
         out_nxt = out_nxt + CNT_W'(avm_bc_q);
      end
      rem_acc  = remaining - LEN_W'(avm_bc_q);
      rem_nxt  = accept ? rem_acc : remaining;
      addr_nxt = avm_addr_q;
      if (accept) begin
         addr_nxt = avm_addr_q + (ADDR_W'(avm_bc_q) << BSH);
      end
      bc_nxt    = burst_of(rem_nxt);
      bc_cmd    = burst_of(bus.cmd_len);
      credit_ok = ({1'b0, fifo_count_nxt} + {1'b0, out_nxt}
                   + (CNT_W + 1)'(bc_nxt)) <= DEPTH;
      td_nxt    = to_deliver - LEN_W'(fifo_rd);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         avm_read_q  <= 1'b0;
         avm_addr_q  <= '0;
         avm_bc_q    <= '0;
         remaining   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_acc) begin
                  if (bus.cmd_len != '0) begin
                     state       <= ISSUE;
                     cmd_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                     avm_read_q  <= 1'b1;
                     avm_addr_q  <= bus.cmd_addr;
                     avm_bc_q    <= bc_cmd;
                     remaining   <= bus.cmd_len;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               remaining  <= rem_nxt;
               avm_addr_q <= addr_nxt;
               if (accept && rem_acc == '0) begin
                  state      <= DRAIN;
                  avm_read_q <= 1'b0;
               end else if (accept || !avm_read_q) begin
                  // A stalled request is left untouched until accepted.
                  avm_bc_q   <= bc_nxt;
                  avm_read_q <= credit_ok;
               end
            end
            DRAIN: begin
               if (td_nxt == '0) begin
                  state       <= IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         fifo_count  <= '0;
         outstanding <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         to_deliver  <= '0;
      end else begin
         fifo_count  <= fifo_count_nxt;
         outstanding <= out_nxt;
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (state == IDLE && cmd_acc) begin
            to_deliver <= bus.cmd_len;
         end else begin
            to_deliver <= td_nxt;
         end
      end
   end

   // Storage only; occupancy lives in the reset counters above.
   always_ff @(posedge clk_clk) begin
      if (fifo_wr) begin
         mem[wr_ptr] <= bus.avm_readdata;
      end
   end

   assign bus.cmd_ready      = cmd_ready_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.avm_read       = avm_read_q;
   assign bus.avm_address    = avm_addr_q;
   assign bus.avm_burstcount = avm_bc_q;
   assign bus.st_data        = mem[rd_ptr];
   assign bus.st_valid       = st_valid;
   assign bus.st_last        = st_valid && (to_deliver == LEN_W'(1));

endmodule

// File: tb/tb_cnn_burst_reader.sv
// Scoreboard bench for cnn_burst_reader: memory-model Avalon slave,
// expected bursts and words queued at command time, popped on output.
module tb_cnn_burst_reader;

   localparam int DW   = 128;
   localparam int AW   = 32;
   localparam int LW   = 24;
   localparam int BC_W = 5;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cnn_burst_reader_if #(
      .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .BC_W(BC_W)
   ) bus ();

   cnn_burst_reader dut (
      .clk_clk    (clk),
      .reset_reset(rst),
      .bus        (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] exp_d  [$];
   bit            exp_l  [$];
   logic [AW-1:0] exp_ba [$];
   int            exp_bn [$];
   logic [AW-1:0] pend   [$];

   bit wr_rand = 0;
   bit rv_rand = 0;
   int sr_mode = 0;

   int n_acc    = 0;
   int n_rd_cyc = 0;
   int n_words  = 0;
   int n_done   = 0;
   int occ      = 0;
   int max_occ  = 0;

   bit            av_hold   = 0;
   logic [AW-1:0] h_addr;
   logic [4:0]    h_bc;
   bit            st_hold   = 0;
   logic [DW-1:0] h_data;
   logic          h_last;
   bit            last_prev = 0;
   logic [AW-1:0] ra;
   logic [AW-1:0] ea;
   int            en;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a ^ 32'hA5A5_5A5A, a + 32'h1357_9BDF, ~a, a};
   endfunction

   // Avalon slave model, stream sink and protocol checks.
   always @(negedge clk) begin
      if (rst) begin
         pend.delete();
         av_hold   = 0;
         st_hold   = 0;
         last_prev = 0;
         occ       = 0;
         bus.avm_waitrequest   = 1'b0;
         bus.avm_readdatavalid = 1'b0;
         bus.avm_readdata      = '0;
         bus.st_ready          = 1'b0;
      end else begin
         if (last_prev) begin
            chk("done_after_last", 128'(bus.done), 128'(1));
         end
         last_prev = 0;
         if (bus.done) begin
            n_done++;
         end

         if (st_hold) begin
            chk("st_hold_valid", 128'(bus.st_valid), 128'(1));
            chk("st_hold_data", bus.st_data, h_data);
            chk("st_hold_last", 128'(bus.st_last), 128'(h_last));
         end
         case (sr_mode)
            0:       bus.st_ready = 1'b1;
            1:       bus.st_ready = 1'($urandom_range(1, 0));
            default: bus.st_ready = 1'b0;
         endcase
         if (bus.st_valid && bus.st_ready) begin
            occ--;
            n_words++;
            chk("word_expected", 128'(exp_d.size() != 0), 128'(1));
            if (exp_d.size() != 0) begin
               chk("st_data", bus.st_data, exp_d.pop_front());
               chk("st_last", 128'(bus.st_last), 128'(exp_l.pop_front()));
            end
            if (bus.st_last) begin
               last_prev = 1;
            end
         end
         st_hold = bus.st_valid && !bus.st_ready;
         h_data  = bus.st_data;
         h_last  = bus.st_last;

         if (pend.size() != 0 && (!rv_rand || $urandom_range(1, 0) == 1)) begin
            ra = pend.pop_front();
            bus.avm_readdata      = mem_word(ra);
            bus.avm_readdatavalid = 1'b1;
            occ++;
            if (occ > max_occ) begin
               max_occ = occ;
            end
         end else begin
            bus.avm_readdatavalid = 1'b0;
         end

         if (av_hold) begin
            chk("stall_read", 128'(bus.avm_read), 128'(1));
            chk("stall_addr", 128'(bus.avm_address), 128'(h_addr));
            chk("stall_bc", 128'(bus.avm_burstcount), 128'(h_bc));
         end
         bus.avm_waitrequest = wr_rand ? 1'($urandom_range(1, 0)) : 1'b0;
         if (bus.avm_read) begin
            n_rd_cyc++;
            if (!bus.avm_waitrequest) begin
               n_acc++;
               chk("burst_expected", 128'(exp_ba.size() != 0), 128'(1));
               if (exp_ba.size() != 0) begin
                  ea = exp_ba.pop_front();
                  en = exp_bn.pop_front();
                  chk("burst_addr", 128'(bus.avm_address), 128'(ea));
                  chk("burst_len", 128'(bus.avm_burstcount), 128'(en));
               end
               for (int i = 0; i < int'(bus.avm_burstcount); i++) begin
                  pend.push_back(bus.avm_address + 32'(i * 16));
               end
            end
            av_hold = bus.avm_waitrequest;
            h_addr  = bus.avm_address;
            h_bc    = bus.avm_burstcount;
         end else begin
            av_hold = 0;
         end
      end
   end

   task automatic push_exp(input logic [AW-1:0] a, input int len);
      logic [AW-1:0] ba;
      int r;
      int b;
      for (int i = 0; i < len; i++) begin
         exp_d.push_back(mem_word(a + 32'(i) * 32'd16));
         exp_l.push_back(i == len - 1);
      end
      ba = a;
      r  = len;
      while (r > 0) begin
         b = (r > 16) ? 16 : r;
         exp_ba.push_back(ba);
         exp_bn.push_back(b);
         ba = ba + 32'(b * 16);
         r  = r - b;
      end
   endtask

   task automatic issue(input logic [AW-1:0] a, input int len);
      int k;
      k = 0;
      @(negedge clk);
      while (!bus.cmd_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_wait", 128'(bus.cmd_ready), 128'(1));
      push_exp(a, len);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_len   = LW'(len);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int k;
      k = 0;
      while (n_done <= d0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, 128'(n_done > d0), 128'(1));
      chk({tag, "_words_left"}, 128'(exp_d.size()), 128'(0));
      chk({tag, "_bursts_left"}, 128'(exp_ba.size()), 128'(0));
   endtask

   task automatic run_cmd(input logic [AW-1:0] a, input int len,
                          input string tag);
      int d0;
      d0 = n_done;
      issue(a, len);
      wait_done(d0, tag);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_avm_read"}, 128'(bus.avm_read), 128'(0));
      chk({tag, "_avm_addr"}, 128'(bus.avm_address), 128'(0));
      chk({tag, "_avm_bc"}, 128'(bus.avm_burstcount), 128'(0));
      chk({tag, "_st_valid"}, 128'(bus.st_valid), 128'(0));
      chk({tag, "_st_last"}, 128'(bus.st_last), 128'(0));
      chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
      chk({tag, "_done"}, 128'(bus.done), 128'(0));
      chk({tag, "_cmd_ready"}, 128'(bus.cmd_ready), 128'(1));
   endtask

   initial begin
      int c0;
      int d0;
      int a0;
      int w0;
      int k;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst0");
      @(posedge clk);
      #1 rst = 1'b0;

      // T1: three bursts, free-running stream
      sr_mode = 0;
      run_cmd(32'h0000_1000, 40, "t1");

      // T2: zero-length command
      c0 = n_rd_cyc;
      d0 = n_done;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 32'h0000_8000;
      bus.cmd_len   = '0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("t2_done", 128'(bus.done), 128'(1));
      chk("t2_busy", 128'(bus.busy), 128'(0));
      @(negedge clk);
      chk("t2_done_pulse", 128'(bus.done), 128'(0));
      chk("t2_busy_after", 128'(bus.busy), 128'(0));
      chk("t2_no_reads", 128'(n_rd_cyc - c0), 128'(0));
      chk("t2_done_count", 128'(n_done - d0), 128'(1));

      // T3: credit limit with a blocked stream
      sr_mode = 2;
      max_occ = 0;
      a0 = n_acc;
      d0 = n_done;
      issue(32'h0000_2000, 200);
      repeat (150) @(negedge clk);
      chk("t3_bursts", 128'(n_acc - a0), 128'(4));
      chk("t3_read_off", 128'(bus.avm_read), 128'(0));
      chk("t3_fill", 128'(occ), 128'(64));
      sr_mode = 1;
      wait_done(d0, "t3");
      chk("t3_max_occ", 128'(max_occ <= 64), 128'(1));

      // T4: random stalls everywhere
      wr_rand = 1;
      rv_rand = 1;
      sr_mode = 1;
      run_cmd(32'h0003_0000, 77, "t4a");
      run_cmd(32'h0000_0040, 33, "t4b");
      wr_rand = 0;
      rv_rand = 0;
      sr_mode = 0;

      // T5: reset mid-command
      w0 = n_words;
      issue(32'h0000_5000, 100);
      k = 0;
      while (n_words - w0 < 30 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("t5_reached_30", 128'(n_words - w0 >= 30), 128'(1));
      @(posedge clk);
      #1 rst = 1'b1;
      exp_d.delete();
      exp_l.delete();
      exp_ba.delete();
      exp_bn.delete();
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs("t5");
      @(posedge clk);
      #1 rst = 1'b0;
      run_cmd(32'h0000_6000, 5, "t5b");

      // T6: address wrap past 2^32
      run_cmd(32'hFFFF_FFC0, 8, "t6a");
      run_cmd(32'hFFFF_FFC0, 20, "t6b");

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
